// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and engine-count check for the sequential DCT stage 2.
package dct_pkg;

    localparam int DCT_N      = 8;
    localparam int COEF_SHIFT = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Integer DCT-II basis: round(32*sqrt(2)*c(k)*cos((2n+1)k*pi/16)), indexed [k][n].
    localparam int COEF [DCT_N][DCT_N] = '{
        '{ 32,  32,  32,  32,  32,  32,  32,  32},
        '{ 44,  38,  25,   9,  -9, -25, -38, -44},
        '{ 42,  17, -17, -42, -42, -17,  17,  42},
        '{ 38,  -9, -44, -25,  25,  44,   9, -38},
        '{ 32, -32, -32,  32,  32, -32, -32,  32},
        '{ 25, -44,   9,  38, -38,  -9,  44, -25},
        '{ 17, -42,  42, -17, -17,  42, -42,  17},
        '{  9, -25,  38, -44,  44, -38,  25,  -9}
    };

    function automatic bit num_eng_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/dct_col_comb.sv
// Purpose: combinational 8-point DCT of one column, optional LSB truncation of each product.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module dct_col_comb
    import dct_pkg::*;
#(
    parameter int SIZE        = 10,
    parameter int APPROX_BITS = 8,
    parameter int SIZE_MULT   = SIZE + 6,
    parameter int SIZE_OUT    = SIZE + 2
) (
    input  logic [DCT_N-1:0][SIZE-1:0]     col_in,
    input  logic                           approx_en,
    output logic [DCT_N-1:0][SIZE_OUT-1:0] col_out
);

    localparam int ACC_W = SIZE_MULT + 3;
    localparam logic [SIZE_MULT-1:0] APPROX_MASK =
        {{(SIZE_MULT-APPROX_BITS){1'b1}}, {APPROX_BITS{1'b0}}};

    logic signed [SIZE_MULT-1:0] x_ext;
    logic signed [SIZE_MULT-1:0] c_ext;
    logic signed [SIZE_MULT-1:0] prod;
    logic signed [ACC_W-1:0]     acc;

    always_comb begin
        col_out = '0;
        x_ext   = '0;
        c_ext   = '0;
        prod    = '0;
        acc     = '0;
        for (int k = 0; k < DCT_N; k++) begin
            acc = '0;
            for (int n = 0; n < DCT_N; n++) begin
                x_ext = {{(SIZE_MULT-SIZE){col_in[n][SIZE-1]}}, col_in[n]};
                c_ext = SIZE_MULT'(COEF[k][n]);
                prod  = x_ext * c_ext;
                // Approximation floors each product to a multiple of 2^APPROX_BITS.
                if (approx_en) begin
                    prod = prod & APPROX_MASK;
                end
                acc = acc + {{(ACC_W-SIZE_MULT){prod[SIZE_MULT-1]}}, prod};
            end
            col_out[k] = SIZE_OUT'(acc >>> COEF_SHIFT);
        end
    end

endmodule

// File: rtl/dct_stage2_seq.sv
// Purpose: second DCT stage, 8 column transforms on NUM_ENG engines time-multiplexed over 8/NUM_ENG passes.
// Latency: out_valid rises 8/NUM_ENG edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY, equals out_ready in DONE.
module dct_stage2_seq
    import dct_pkg::*;
#(
    parameter int SIZE        = 10,
    parameter int APPROX_BITS = 8,
    parameter int SIZE_MULT   = SIZE + 6,
    parameter int SIZE_OUT    = SIZE + 2,
    parameter int NUM_ENG     = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DCT_N-1:0][DCT_N-1:0][SIZE-1:0]     data_in,
    input  logic                                      approx_en,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DCT_N-1:0][DCT_N-1:0][SIZE_OUT-1:0] data_out,
    output logic                                      busy
);

    localparam int IDX_W    = $clog2(DCT_N);
    localparam int LAST_IDX = DCT_N - NUM_ENG;

    if (!num_eng_legal(NUM_ENG)) begin : g_bad_num_eng
        $error("dct_stage2_seq: NUM_ENG must be 1, 2, 4 or 8");
    end

    state_t                                  state;
    logic [IDX_W-1:0]                        col_idx;
    logic [DCT_N-1:0][DCT_N-1:0][SIZE-1:0]   data_in_reg;
    logic                                    approx_reg;
    logic [DCT_N-1:0][SIZE_OUT-1:0]          eng_out [NUM_ENG];
    logic                                    accept;

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign busy     = (state == ST_BUSY);
    assign accept   = in_valid && in_ready;

    // Engine e always works on column col_idx+e of the captured block.
    for (genvar e = 0; e < NUM_ENG; e++) begin : g_eng
        dct_col_comb #(
            .SIZE        (SIZE),
            .APPROX_BITS (APPROX_BITS),
            .SIZE_MULT   (SIZE_MULT),
            .SIZE_OUT    (SIZE_OUT)
        ) u_col (
            .col_in    (data_in_reg[col_idx + IDX_W'(e)]),
            .approx_en (approx_reg),
            .col_out   (eng_out[e])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            col_idx     <= '0;
            out_valid   <= 1'b0;
            data_out    <= '0;
            data_in_reg <= '0;
            approx_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        data_in_reg <= data_in;
                        approx_reg  <= approx_en;
                        col_idx     <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int e = 0; e < NUM_ENG; e++) begin
                        data_out[col_idx + IDX_W'(e)] <= eng_out[e];
                    end
                    if (col_idx == IDX_W'(LAST_IDX)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        col_idx <= col_idx + IDX_W'(NUM_ENG % DCT_N);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // A waiting block is taken on the same edge to keep back-to-back throughput.
                        if (in_valid) begin
                            data_in_reg <= data_in;
                            approx_reg  <= approx_en;
                            col_idx     <= '0;
                            state       <= ST_BUSY;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_stage2_seq.sv
// Directed bench for dct_stage2_seq: four instances with NUM_ENG = 1, 2, 4, 8 on one clock.
module tb_dct_stage2_seq;

    typedef logic [7:0][7:0][9:0]  blk_in_t;
    typedef logic [7:0][7:0][11:0] blk_out_t;

    logic     clk;
    logic     rst_n;
    blk_in_t  data_in;
    logic     approx_en;
    logic     in_valid  [4];
    logic     out_ready [4];
    logic     in_ready  [4];
    logic     out_valid [4];
    logic     busy      [4];
    blk_out_t dout      [4];

    int checks = 0;
    int errors = 0;
    int coef_t [8][8];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dct_stage2_seq #(.NUM_ENG(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in),
            .approx_en (approx_en),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (dout[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Reference: textbook DCT-II coefficients, exact integer products, floor division.
    function automatic blk_out_t model(input blk_in_t b, input logic ap);
        blk_out_t r;
        int acc;
        int p;
        int x;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) begin
                acc = 0;
                for (int n = 0; n < 8; n++) begin
                    x = $signed(b[c][n]);
                    p = coef_t[k][n] * x;
                    if (ap) p = (p >>> 8) * 256;
                    acc += p;
                end
                r[c][k] = 12'(acc >>> 6);
            end
        end
        return r;
    endfunction

    function automatic blk_in_t rand_blk();
        blk_in_t r;
        for (int c = 0; c < 8; c++)
            for (int n = 0; n < 8; n++)
                r[c][n] = 10'($urandom_range(0, 1023));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input blk_out_t obs, input blk_out_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offers one block to instance idx, scrambles inputs after acceptance, counts edges to out_valid.
    task automatic send(input int idx, input blk_in_t b, input logic ap, input logic flip, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready[idx], 1'b1);
        data_in       = b;
        approx_en     = ap;
        in_valid[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        data_in       = ~b;
        if (flip) approx_en = ~ap;
        chk("busy_after_accept", busy[idx], 1'b1);
        lat = 0;
        while (!out_valid[idx] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        blk_in_t  b;
        blk_in_t  bb [3];
        blk_out_t exp;
        int       lat;

        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                coef_t[k][n] = rnd(32.0 * $sqrt(2.0) * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0)
                                   * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0));

        rst_n     = 1'b0;
        data_in   = '0;
        approx_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_valid", out_valid[i], 1'b0);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_in_ready", in_ready[i], 1'b1);
            chk_blk("rst_data_out", dout[i], '0);
        end

        // NUM_ENG=8, flat block of 100: DC = 32*800/64 = 400, every AC term 0
        out_ready[3] = 1'b1;
        for (int c = 0; c < 8; c++)
            for (int n = 0; n < 8; n++)
                b[c][n] = 10'd100;
        exp = '0;
        for (int c = 0; c < 8; c++) exp[c][0] = 12'd400;
        send(3, b, 1'b0, 1'b0, lat);
        chk("lat_eng8", lat, 1);
        chk_blk("flat_block_eng8", dout[3], exp);
        @(negedge clk);
        chk("eng8_drop", out_valid[3], 1'b0);

        // NUM_ENG=2, random block
        out_ready[1] = 1'b1;
        b = rand_blk();
        send(1, b, 1'b0, 1'b0, lat);
        chk("lat_eng2", lat, 4);
        chk_blk("rand_block_eng2", dout[1], model(b, 1'b0));

        // NUM_ENG=1, downstream stalls 10 cycles in DONE
        out_ready[0] = 1'b0;
        b = rand_blk();
        exp = model(b, 1'b0);
        send(0, b, 1'b0, 1'b0, lat);
        chk("lat_eng1", lat, 8);
        for (int i = 0; i < 10; i++) begin
            chk_blk("stall_data_stable", dout[0], exp);
            chk("stall_out_valid", out_valid[0], 1'b1);
            chk("stall_in_ready", in_ready[0], 1'b0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1;
        chk("done_in_ready_follows", in_ready[0], 1'b1);
        @(negedge clk);
        chk("stall_drop_first_edge", out_valid[0], 1'b0);
        chk("stall_back_idle", in_ready[0], 1'b1);

        // NUM_ENG=4 back-to-back, in_valid and out_ready held high
        out_ready[2] = 1'b1;
        for (int c = 0; c < 8; c++)
            for (int n = 0; n < 8; n++)
                bb[0][c][n] = ((c + n) % 2 == 1) ? 10'h1FF : 10'h200;
        bb[1] = rand_blk();
        bb[2] = rand_blk();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_in_ready_accept", in_ready[2], 1'b1);
            if (i > 0) begin
                chk("b2b_out_valid", out_valid[2], 1'b1);
                chk_blk("b2b_data", dout[2], model(bb[i-1], 1'b0));
            end
            data_in     = bb[i];
            in_valid[2] = 1'b1;
            @(negedge clk);
            chk("b2b_busy_pass1", in_ready[2], 1'b0);
            data_in = ~bb[i];
            @(negedge clk);
            chk("b2b_busy_pass2", in_ready[2], 1'b0);
            @(negedge clk);
        end
        in_valid[2] = 1'b0;
        chk("b2b_last_out_valid", out_valid[2], 1'b1);
        chk_blk("b2b_last_data", dout[2], model(bb[2], 1'b0));
        @(negedge clk);

        // Reset after 2 of 4 passes on NUM_ENG=2
        b = rand_blk();
        data_in     = b;
        in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", busy[1], 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid[1], 1'b0);
        chk_blk("midrst_data_out", dout[1], '0);
        chk("midrst_in_ready", in_ready[1], 1'b1);
        chk("midrst_busy", busy[1], 1'b0);
        rst_n = 1'b1;
        b = rand_blk();
        send(1, b, 1'b0, 1'b0, lat);
        chk("lat_after_reset", lat, 4);
        chk_blk("block_after_reset", dout[1], model(b, 1'b0));

        // approx_en=1 at accept, toggled to 0 during BUSY
        for (int c = 0; c < 8; c++)
            for (int n = 0; n < 8; n++)
                b[c][n] = 10'(((c * 37 + n * 91) % 1024) - 512);
        send(1, b, 1'b1, 1'b1, lat);
        chk("lat_approx", lat, 4);
        chk_blk("approx_frozen", dout[1], model(b, 1'b1));
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
